// File: rtl/store_write_buffer_if.sv
// Store-queue issue port, bus write-master port, load lookup and fence status
// of the posted-write buffer, bundled so both sides connect through one port.
interface store_write_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [3:0]  in_be;
    logic [31:0] in_data;
    logic        in_strictly_ordered;
    logic        drain;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_data;
    logic        bus_ack;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    logic        empty;

    // Store queue / bus / LSU side.
    modport master (
        output in_valid, in_addr, in_be, in_data, in_strictly_ordered, drain,
        output bus_req_ready, bus_ack, lookup_addr,
        input  in_ready, bus_req_valid, bus_addr, bus_be, bus_data,
        input  lookup_hit, empty
    );

    // Write buffer side.
    modport slave (
        input  in_valid, in_addr, in_be, in_data, in_strictly_ordered, drain,
        input  bus_req_ready, bus_ack, lookup_addr,
        output in_ready, bus_req_valid, bus_addr, bus_be, bus_data,
        output lookup_hit, empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write buffer: in-order FIFO of word-granular stores with same-word
// coalescing into the youngest entry, bounded outstanding bus writes,
// load same-word hit detection and an empty flag for fences.
module store_write_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    store_write_buffer_if.slave io
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    logic [29:0]      ent_word [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_so;
    logic [DEPTH-1:0] ent_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] youngest;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] outstanding;

    logic accept;
    logic merge;
    logic push;
    logic issue;

    // Byte-offset bits only describe the original access; matching is per word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{io.in_addr[1:0], io.lookup_addr[1:0]};

    // Accept/merge/push decision and bus request qualification.
    // Merging needs count>=2 so the youngest entry is never the frozen head,
    // even when that head issues in the same cycle.
    always_comb begin
        youngest         = tail - PTR_W'(1);
        io.in_ready      = (count != CNT_FULL);
        accept           = io.in_valid && io.in_ready && (io.in_be != 4'b0000);
        merge            = accept && (count >= CNT_TWO)
                           && (ent_word[youngest] == io.in_addr[31:2])
                           && !io.in_strictly_ordered && !ent_so[youngest]
                           && !io.drain;
        push             = accept && !merge;
        io.bus_req_valid = (count != '0) && (outstanding < OUT_MAX)
                           && (!ent_so[head] || (outstanding == '0));
        issue            = io.bus_req_valid && io.bus_req_ready;
    end

    // Bus payload comes straight from the head entry; empty covers in-flight writes.
    always_comb begin
        io.bus_addr = {ent_word[head], 2'b00};
        io.bus_be   = ent_be[head];
        io.bus_data = ent_data[head];
        io.empty    = (count == '0) && (outstanding == '0);
    end

    // Load hit check against buffered (not yet issued) entries.
    always_comb begin
        io.lookup_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_word[i] == io.lookup_addr[31:2])) begin
                io.lookup_hit = 1'b1;
            end
        end
    end

    // Pointers, occupancy, outstanding-write count and per-entry flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            ent_valid   <= '0;
            ent_so      <= '0;
        end else begin
            if (push) begin
                tail              <= tail + PTR_W'(1);
                ent_valid[tail]   <= 1'b1;
                ent_so[tail]      <= io.in_strictly_ordered;
            end
            if (issue) begin
                head              <= head + PTR_W'(1);
                ent_valid[head]   <= 1'b0;
            end
            if (push && !issue) begin
                count <= count + CNT_W'(1);
            end else if (!push && issue) begin
                count <= count - CNT_W'(1);
            end
            if (issue && !io.bus_ack) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!issue && io.bus_ack) begin
                outstanding <= outstanding - OUT_W'(1);
            end
        end
    end

    // Entry payload: fresh write at tail, or byte-wise coalesce into the youngest.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_word[tail] <= io.in_addr[31:2];
            ent_be[tail]   <= io.in_be;
            ent_data[tail] <= io.in_data;
        end else if (merge) begin
            ent_be[youngest] <= ent_be[youngest] | io.in_be;
            for (int unsigned b = 0; b < 4; b++) begin
                if (io.in_be[b]) begin
                    ent_data[youngest][8*b +: 8] <= io.in_data[8*b +: 8];
                end
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count != CNT_FULL));
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= OUT_MAX);
    a_ack_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        io.bus_ack |-> (outstanding != '0));
    a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (io.bus_req_valid && !io.bus_req_ready) |=>
        (io.bus_req_valid && $stable({io.bus_addr, io.bus_be, io.bus_data})));
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_store_write_buffer;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    store_write_buffer_if bus_if ();

    store_write_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus_if)
    );

    typedef struct {
        logic [29:0] w;
        logic [3:0]  be;
        logic [31:0] d;
        logic        so;
    } ent_t;

    ent_t mq[$];
    int   m_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_valid();
        return (mq.size() != 0) && (m_out < MAX_OUT) && (!mq[0].so || m_out == 0);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].w == a[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic model_update();
        bit   rdy, iss, acc, mrg;
        ent_t e;
        rdy = mq.size() < DEPTH;
        iss = m_valid() && bus_if.bus_req_ready;
        acc = bus_if.in_valid && rdy && (bus_if.in_be != 4'b0);
        mrg = acc && (mq.size() >= 2) && (mq[$].w == bus_if.in_addr[31:2])
              && !bus_if.in_strictly_ordered && !mq[$].so && !bus_if.drain;
        if (mrg) begin
            e = mq[$];
            for (int b = 0; b < 4; b++)
                if (bus_if.in_be[b]) e.d[8*b +: 8] = bus_if.in_data[8*b +: 8];
            e.be = e.be | bus_if.in_be;
            mq[$] = e;
        end else if (acc) begin
            e.w  = bus_if.in_addr[31:2];
            e.be = bus_if.in_be;
            e.d  = bus_if.in_data;
            e.so = bus_if.in_strictly_ordered;
            mq.push_back(e);
        end
        if (iss) void'(mq.pop_front());
        m_out = m_out + (iss ? 1 : 0) - (bus_if.bus_ack ? 1 : 0);
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus_if.in_valid            = 1'b0;
        bus_if.in_addr             = '0;
        bus_if.in_be               = '0;
        bus_if.in_data             = '0;
        bus_if.in_strictly_ordered = 1'b0;
        bus_if.drain               = 1'b0;
        bus_if.bus_req_ready       = 1'b0;
        bus_if.bus_ack             = 1'b0;
        bus_if.lookup_addr         = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        mq.delete();
        m_out = 0;
        rst_n = 1'b1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d, input logic so, input logic drn);
        bus_if.in_valid            = 1'b1;
        bus_if.in_addr             = a;
        bus_if.in_be               = be;
        bus_if.in_data             = d;
        bus_if.in_strictly_ordered = so;
        bus_if.drain               = drn;
        tick();
        bus_if.in_valid            = 1'b0;
        bus_if.in_strictly_ordered = 1'b0;
        bus_if.drain               = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); end
        n_tests++; if (bus_if.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus_if.bus_req_valid); end
        n_tests++; if (bus_if.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lookup_hit: got %b want 0", bus_if.lookup_hit); end
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus_if.empty); end
    endtask

    task automatic test_fill();
        logic [31:0] d0;
        do_reset();
        d0 = $urandom;
        push_store(32'h100, 4'hF, d0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) push_store(32'h100 + 32'(4 * i), 4'hF, $urandom, 1'b0, 1'b0);
        #1;
        n_tests++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", bus_if.in_ready); end
        n_tests++; if (bus_if.bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL fill_req_valid: got %b want 1", bus_if.bus_req_valid); end
        n_tests++; if (bus_if.bus_data !== d0) begin n_fail++; $display("FAIL fill_data: got %h want %h", bus_if.bus_data, d0); end
        // a fifth store is refused while full
        push_store(32'h110, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus_if.bus_addr !== 32'h100 || bus_if.bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL fill_hold: got addr %h valid %b want 100 1", bus_if.bus_addr, bus_if.bus_req_valid); end
            tick();
        end
        #1;
        n_tests++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_still_full: got %b want 0", bus_if.in_ready); end
        bus_if.bus_req_ready = 1'b1;
        tick();
        bus_if.bus_req_ready = 1'b0;
        #1;
        n_tests++; if (bus_if.in_ready !== 1'b1 || bus_if.bus_addr !== 32'h104) begin n_fail++; $display("FAIL fill_after_issue: got rdy %b addr %h want 1 104", bus_if.in_ready, bus_if.bus_addr); end
    endtask

    task automatic test_merge();
        do_reset();
        push_store(32'h300, 4'hF, 32'h1111_1111, 1'b0, 1'b0);
        push_store(32'h200, 4'b0011, 32'h0000_AABB, 1'b0, 1'b0);
        push_store(32'h201, 4'b1100, 32'hCCDD_0000, 1'b0, 1'b0);
        #1;
        n_tests++; if (bus_if.bus_addr !== 32'h300) begin n_fail++; $display("FAIL merge_head: got %h want 300", bus_if.bus_addr); end
        bus_if.bus_req_ready = 1'b1;
        tick();
        #1;
        n_tests++; if ({bus_if.bus_req_valid, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_data} !== {1'b1, 32'h200, 4'hF, 32'hCCDD_AABB})
            begin n_fail++; $display("FAIL merge_entry: got v%b %h be %b %h want v1 200 be 1111 ccddaabb", bus_if.bus_req_valid, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_data); end
        tick();
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_ack = 1'b1;
        tick();
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL merge_two_entries_empty: got %b want 1", bus_if.empty); end
    endtask

    // Variant 0: second store strictly ordered (also holds the bus until idle).
    // Variant 1: drain blocks merging.
    task automatic test_no_merge();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            push_store(32'h300, 4'hF, 32'h1111_1111, 1'b0, 1'b0);
            push_store(32'h200, 4'b0011, 32'h0000_AABB, 1'b0, 1'b0);
            push_store(32'h200, 4'b1100, 32'hCCDD_0000, v == 0, v == 1);
            bus_if.bus_req_ready = 1'b1;
            #1;
            n_tests++; if (bus_if.bus_addr !== 32'h300) begin n_fail++; $display("FAIL nomerge%0d_first: got %h want 300", v, bus_if.bus_addr); end
            tick();
            #1;
            n_tests++; if ({bus_if.bus_addr, bus_if.bus_be, bus_if.bus_data} !== {32'h200, 4'b0011, 32'h0000_AABB})
                begin n_fail++; $display("FAIL nomerge%0d_second: got %h %b %h want 200 0011 0000aabb", v, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_data); end
            tick();
            #1;
            n_tests++; if (bus_if.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL nomerge%0d_out_limit: got %b want 0", v, bus_if.bus_req_valid); end
            bus_if.bus_req_ready = 1'b0;
            bus_if.bus_ack = 1'b1;
            tick();
            bus_if.bus_ack = 1'b0;
            #1;
            n_tests++; if (bus_if.bus_req_valid !== (v == 1)) begin n_fail++; $display("FAIL nomerge%0d_one_out: got %b want %b", v, bus_if.bus_req_valid, v == 1); end
            bus_if.bus_ack = 1'b1;
            tick();
            bus_if.bus_ack = 1'b0;
            #1;
            n_tests++; if ({bus_if.bus_req_valid, bus_if.bus_be, bus_if.bus_data} !== {1'b1, 4'b1100, 32'hCCDD_0000})
                begin n_fail++; $display("FAIL nomerge%0d_third: got v%b %b %h want v1 1100 ccdd0000", v, bus_if.bus_req_valid, bus_if.bus_be, bus_if.bus_data); end
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        bus_if.in_valid = 1'b1;
        bus_if.in_addr  = 32'h500;
        bus_if.in_be    = 4'hF;
        bus_if.in_data  = $urandom;
        #1;
        n_tests++; if (bus_if.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL comb_path: got %b want 0", bus_if.bus_req_valid); end
        tick();
        bus_if.in_valid = 1'b0;
        push_store(32'h504, 4'hF, $urandom, 1'b0, 1'b0);
        push_store(32'h508, 4'hF, $urandom, 1'b0, 1'b0);
        bus_if.bus_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++; if (bus_if.bus_req_valid !== 1'b1 || bus_if.bus_addr !== 32'h500 + 32'(4 * i))
                begin n_fail++; $display("FAIL out_issue%0d: got v%b %h want v1 %h", i, bus_if.bus_req_valid, bus_if.bus_addr, 32'h500 + 32'(4 * i)); end
            tick();
        end
        tick();
        #1;
        n_tests++; if (bus_if.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL out_blocked: got %b want 0", bus_if.bus_req_valid); end
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++; if (bus_if.bus_req_valid !== 1'b1 || bus_if.bus_addr !== 32'h508) begin n_fail++; $display("FAIL out_third: got v%b %h want v1 508", bus_if.bus_req_valid, bus_if.bus_addr); end
        tick();
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_ack = 1'b1;
        tick();
        #1;
        n_tests++; if (bus_if.empty !== 1'b0) begin n_fail++; $display("FAIL out_not_empty: got %b want 0", bus_if.empty); end
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        n_tests++; if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL out_empty: got %b want 1", bus_if.empty); end
    endtask

    task automatic test_zero_be();
        do_reset();
        push_store(32'h600, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        #1;
        n_tests++; if (bus_if.empty !== 1'b1 || bus_if.bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL zero_be: got empty %b valid %b want 1 0", bus_if.empty, bus_if.bus_req_valid); end
    endtask

    task automatic test_lookup_reset();
        do_reset();
        push_store(32'h400, 4'hF, $urandom, 1'b0, 1'b0);
        bus_if.lookup_addr = 32'h402;
        #1;
        n_tests++; if (bus_if.lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_same_word: got %b want 1", bus_if.lookup_hit); end
        bus_if.lookup_addr = 32'h404;
        #1;
        n_tests++; if (bus_if.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_other_word: got %b want 0", bus_if.lookup_hit); end
        bus_if.lookup_addr = 32'h400;
        bus_if.bus_req_ready = 1'b1;
        tick();
        bus_if.bus_req_ready = 1'b0;
        #1;
        n_tests++; if (bus_if.lookup_hit !== 1'b0 || bus_if.empty !== 1'b0) begin n_fail++; $display("FAIL lookup_issued: got hit %b empty %b want 0 0", bus_if.lookup_hit, bus_if.empty); end
        push_store(32'h408, 4'hF, $urandom, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus_if.empty !== 1'b1 || bus_if.bus_req_valid !== 1'b0 || bus_if.in_ready !== 1'b1)
            begin n_fail++; $display("FAIL async_reset: got empty %b valid %b rdy %b want 1 0 1", bus_if.empty, bus_if.bus_req_valid, bus_if.in_ready); end
        idle_inputs();
        @(negedge clk);
        mq.delete();
        m_out = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] exp_addr;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus_if.in_valid            = ($urandom_range(0, 3) != 0);
            bus_if.in_addr             = 32'h700 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            bus_if.in_be               = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            bus_if.in_data             = $urandom;
            bus_if.in_strictly_ordered = ($urandom_range(0, 9) == 0);
            bus_if.drain               = ($urandom_range(0, 7) == 0);
            bus_if.bus_req_ready       = ($urandom_range(0, 2) != 0);
            bus_if.bus_ack             = (m_out > 0) && ($urandom_range(0, 2) == 0);
            bus_if.lookup_addr         = 32'h700 + 32'($urandom_range(0, 4) * 4);
            #1;
            n_tests++; if (bus_if.in_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, bus_if.in_ready, mq.size() < DEPTH); end
            n_tests++; if (bus_if.bus_req_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_req_valid@%0d: got %b want %b", cyc, bus_if.bus_req_valid, m_valid()); end
            if (mq.size() != 0) begin
                exp_addr = {mq[0].w, 2'b00};
                n_tests++; if ({bus_if.bus_addr, bus_if.bus_be, bus_if.bus_data} !== {exp_addr, mq[0].be, mq[0].d})
                    begin n_fail++; $display("FAIL rnd_payload@%0d: got %h %b %h want %h %b %h", cyc, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_data, exp_addr, mq[0].be, mq[0].d); end
            end
            n_tests++; if (bus_if.lookup_hit !== m_hit(bus_if.lookup_addr)) begin n_fail++; $display("FAIL rnd_lookup@%0d: got %b want %b", cyc, bus_if.lookup_hit, m_hit(bus_if.lookup_addr)); end
            n_tests++; if (bus_if.empty !== (mq.size() == 0 && m_out == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %b want %b", cyc, bus_if.empty, mq.size() == 0 && m_out == 0); end
            tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_out   = 0;
        rst_n   = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_merge();
        test_no_merge();
        test_outstanding();
        test_zero_be();
        test_lookup_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
